// File: rtl/load_store_queue_pkg.sv
// Shared constants and types for the load/store queue.
// The instruction type field is {store, unsigned, size[1:0]}.
package load_store_queue_pkg;

  localparam int LS_TYPE_BIT     = 4;
  localparam int LS_STORE_POS    = 3;
  localparam int LS_UNSIGNED_POS = 2;
  localparam int LS_SIZE_MSB     = 1;
  localparam int LS_SIZE_LSB     = 0;

  localparam int          LSQ_DEF_SIZE_BIT      = 3;
  localparam int          LSQ_DEF_ROB_WIDTH_BIT = 4;
  localparam logic [31:0] LSQ_DEF_IO_BASE       = 32'h0003_0000;

  typedef enum logic [1:0] {
    LSQ_IDLE,
    LSQ_BUSY,
    LSQ_DRAIN
  } lsq_state_e;

  // Effective address: base plus sign-extended 12-bit immediate.
  function automatic logic [31:0] lsq_eff_addr(input logic [31:0] base, input logic [11:0] off);
    return base + {{20{off[11]}}, off};
  endfunction

endpackage

// File: rtl/lsq_cdb_match.sv
// Compares one pending operand tag against every CDB port.
// Purely combinational; when several ports carry the tag, the lowest port wins.
module lsq_cdb_match #(
  parameter int ROB_WIDTH_BIT = 4,
  parameter int CDB_PORTS     = 2
) (
  input  logic [ROB_WIDTH_BIT-1:0]           dep_i,
  input  logic                               has_dep_i,
  input  logic [CDB_PORTS-1:0]               cdb_valid_i,
  input  logic [CDB_PORTS*ROB_WIDTH_BIT-1:0] cdb_rob_id_i,
  input  logic [CDB_PORTS*32-1:0]            cdb_value_i,
  output logic                               hit_o,
  output logic [31:0]                        value_o
);

  // Scan from the highest port down so the lowest matching port is written last.
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (has_dep_i && cdb_valid_i[p] &&
          (cdb_rob_id_i[p*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == dep_i)) begin
        hit_o   = 1'b1;
        value_o = cdb_value_i[p*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: collects memory ops from the decoder, wakes their
// operands from the CDB, and sends one cache request at a time from the head.
// Stores and IO loads wait until they own the ROB head; other loads go early.
// Optional build macro LSQ_PERF_CNT_EN adds saturating performance counters.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int          LSQ_SIZE_BIT  = LSQ_DEF_SIZE_BIT,
  parameter int          ROB_WIDTH_BIT = LSQ_DEF_ROB_WIDTH_BIT,
  parameter int          CDB_PORTS     = 2,
  parameter logic [31:0] IO_BASE       = LSQ_DEF_IO_BASE
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               rdy_in,
  input  logic                               inst_valid,
  input  logic [LS_TYPE_BIT-1:0]             inst_type,
  input  logic [31:0]                        inst_r1,
  input  logic [31:0]                        inst_r2,
  input  logic [ROB_WIDTH_BIT-1:0]           inst_dep1,
  input  logic [ROB_WIDTH_BIT-1:0]           inst_dep2,
  input  logic                               inst_has_dep1,
  input  logic                               inst_has_dep2,
  input  logic [11:0]                        inst_offset,
  input  logic [ROB_WIDTH_BIT-1:0]           inst_rob_id,
  output logic                               full,
  input  logic [CDB_PORTS-1:0]               cdb_valid,
  input  logic [CDB_PORTS*ROB_WIDTH_BIT-1:0] cdb_rob_id,
  input  logic [CDB_PORTS*32-1:0]            cdb_value,
  input  logic                               rob_empty,
  input  logic [ROB_WIDTH_BIT-1:0]           rob_head_id,
  input  logic                               rob_clear,
  output logic                               cache_valid,
  output logic                               cache_wr,
  output logic [2:0]                         cache_size,
  output logic [31:0]                        cache_addr,
  output logic [31:0]                        cache_value,
  input  logic                               cache_ready,
  input  logic [31:0]                        cache_res,
  output logic                               lsq_ready,
  output logic [ROB_WIDTH_BIT-1:0]           lsq_rob_id,
  output logic [31:0]                        lsq_value
`ifdef LSQ_PERF_CNT_EN
  ,
  output logic [31:0]                        perf_loads,
  output logic [31:0]                        perf_stores,
  output logic [31:0]                        perf_stall_cycles
`endif
);

  localparam int                     LSQ_SIZE = 1 << LSQ_SIZE_BIT;
  localparam logic [LSQ_SIZE_BIT:0]  CNT_FULL = (LSQ_SIZE_BIT + 1)'(LSQ_SIZE);

  // Entry storage
  logic                     busy_q     [LSQ_SIZE];
  logic [LS_TYPE_BIT-1:0]   type_q     [LSQ_SIZE];
  logic [31:0]              r1_q       [LSQ_SIZE];
  logic [31:0]              r2_q       [LSQ_SIZE];
  logic [ROB_WIDTH_BIT-1:0] dep1_q     [LSQ_SIZE];
  logic [ROB_WIDTH_BIT-1:0] dep2_q     [LSQ_SIZE];
  logic                     has_dep1_q [LSQ_SIZE];
  logic                     has_dep2_q [LSQ_SIZE];
  logic [11:0]              offset_q   [LSQ_SIZE];
  logic [ROB_WIDTH_BIT-1:0] rob_id_q   [LSQ_SIZE];

  logic [LSQ_SIZE_BIT-1:0] head_q, tail_q;
  logic [LSQ_SIZE_BIT:0]   count_q;
  lsq_state_e              state_q;

  // Registered cache/result outputs plus what the in-flight request was
  logic                     cache_valid_q, cache_wr_q;
  logic [2:0]               cache_size_q;
  logic [31:0]              cache_addr_q, cache_value_q;
  logic                     lsq_ready_q;
  logic [ROB_WIDTH_BIT-1:0] lsq_rob_id_q, inflight_rob_q;
  logic [31:0]              lsq_value_q;
  logic                     inflight_store_q;

  logic        push_en, pop_en, flush, do_issue;
  logic        push_hit1, push_hit2;
  logic [31:0] push_val1, push_val2;
  logic [31:0] head_addr;
  logic        head_store, head_io, head_ready, head_at_commit, issue_ok;

  assign full = (count_q == CNT_FULL);

  // While rdy_in is low only the cache return is processed; everything else holds.
  assign flush   = rdy_in && rob_clear;
  assign push_en = rdy_in && inst_valid && !full && !rob_clear;
  assign pop_en  = cache_ready && (state_q == LSQ_BUSY) && !flush;

  assign head_addr      = lsq_eff_addr(r1_q[head_q], offset_q[head_q]);
  assign head_store     = type_q[head_q][LS_STORE_POS];
  assign head_io        = (head_addr >= IO_BASE);
  assign head_ready     = busy_q[head_q] && !has_dep1_q[head_q] && !has_dep2_q[head_q];
  assign head_at_commit = !rob_empty && (rob_head_id == rob_id_q[head_q]);
  assign issue_ok       = head_ready && ((!head_store && !head_io) || head_at_commit);
  assign do_issue       = rdy_in && !rob_clear && (state_q == LSQ_IDLE) && issue_ok;

  // Operands broadcast in the same cycle as the push are captured directly.
  lsq_cdb_match #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT), .CDB_PORTS(CDB_PORTS)) u_push_match1 (
    .dep_i(inst_dep1), .has_dep_i(inst_has_dep1), .cdb_valid_i(cdb_valid),
    .cdb_rob_id_i(cdb_rob_id), .cdb_value_i(cdb_value), .hit_o(push_hit1), .value_o(push_val1)
  );
  lsq_cdb_match #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT), .CDB_PORTS(CDB_PORTS)) u_push_match2 (
    .dep_i(inst_dep2), .has_dep_i(inst_has_dep2), .cdb_valid_i(cdb_valid),
    .cdb_rob_id_i(cdb_rob_id), .cdb_value_i(cdb_value), .hit_o(push_hit2), .value_o(push_val2)
  );

  for (genvar gi = 0; gi < LSQ_SIZE; gi++) begin : g_entry
    logic        hit1, hit2;
    logic [31:0] val1, val2;
    logic        wr_here, pop_here;

    lsq_cdb_match #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT), .CDB_PORTS(CDB_PORTS)) u_match1 (
      .dep_i(dep1_q[gi]), .has_dep_i(has_dep1_q[gi]), .cdb_valid_i(cdb_valid),
      .cdb_rob_id_i(cdb_rob_id), .cdb_value_i(cdb_value), .hit_o(hit1), .value_o(val1)
    );
    lsq_cdb_match #(.ROB_WIDTH_BIT(ROB_WIDTH_BIT), .CDB_PORTS(CDB_PORTS)) u_match2 (
      .dep_i(dep2_q[gi]), .has_dep_i(has_dep2_q[gi]), .cdb_valid_i(cdb_valid),
      .cdb_rob_id_i(cdb_rob_id), .cdb_value_i(cdb_value), .hit_o(hit2), .value_o(val2)
    );

    assign wr_here  = push_en && (tail_q == LSQ_SIZE_BIT'(gi));
    assign pop_here = pop_en && (head_q == LSQ_SIZE_BIT'(gi));

    // Allocate on push, wake operands from the CDB, release on pop or flush.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        busy_q[gi]     <= 1'b0;
        type_q[gi]     <= '0;
        r1_q[gi]       <= '0;
        r2_q[gi]       <= '0;
        dep1_q[gi]     <= '0;
        dep2_q[gi]     <= '0;
        has_dep1_q[gi] <= 1'b0;
        has_dep2_q[gi] <= 1'b0;
        offset_q[gi]   <= '0;
        rob_id_q[gi]   <= '0;
      end else if (flush) begin
        busy_q[gi]     <= 1'b0;
        has_dep1_q[gi] <= 1'b0;
        has_dep2_q[gi] <= 1'b0;
      end else if (wr_here) begin
        busy_q[gi]     <= 1'b1;
        type_q[gi]     <= inst_type;
        r1_q[gi]       <= push_hit1 ? push_val1 : inst_r1;
        r2_q[gi]       <= push_hit2 ? push_val2 : inst_r2;
        dep1_q[gi]     <= inst_dep1;
        dep2_q[gi]     <= inst_dep2;
        has_dep1_q[gi] <= inst_has_dep1 && !push_hit1;
        has_dep2_q[gi] <= inst_has_dep2 && !push_hit2;
        offset_q[gi]   <= inst_offset;
        rob_id_q[gi]   <= inst_rob_id;
      end else if (pop_here) begin
        busy_q[gi] <= 1'b0;
      end else if (rdy_in && busy_q[gi]) begin
        if (hit1) begin
          r1_q[gi]       <= val1;
          has_dep1_q[gi] <= 1'b0;
        end
        if (hit2) begin
          r2_q[gi]       <= val2;
          has_dep2_q[gi] <= 1'b0;
        end
      end
    end
  end

  // Head/tail/count bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) tail_q <= tail_q + 1'b1;
      if (pop_en)  head_q <= head_q + 1'b1;
      count_q <= count_q + {{LSQ_SIZE_BIT{1'b0}}, push_en} - {{LSQ_SIZE_BIT{1'b0}}, pop_en};
    end
  end

  // Request FSM with registered cache and result outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= LSQ_IDLE;
      cache_valid_q    <= 1'b0;
      cache_wr_q       <= 1'b0;
      cache_size_q     <= '0;
      cache_addr_q     <= '0;
      cache_value_q    <= '0;
      lsq_ready_q      <= 1'b0;
      lsq_rob_id_q     <= '0;
      lsq_value_q      <= '0;
      inflight_rob_q   <= '0;
      inflight_store_q <= 1'b0;
    end else begin
      lsq_ready_q <= 1'b0;
      case (state_q)
        LSQ_IDLE: begin
          if (do_issue) begin
            state_q          <= LSQ_BUSY;
            cache_valid_q    <= 1'b1;
            cache_wr_q       <= head_store;
            cache_size_q     <= {type_q[head_q][LS_UNSIGNED_POS], type_q[head_q][LS_SIZE_MSB:LS_SIZE_LSB]};
            cache_addr_q     <= head_addr;
            cache_value_q    <= head_store ? r2_q[head_q] : 32'd0;
            inflight_rob_q   <= rob_id_q[head_q];
            inflight_store_q <= head_store;
          end
        end
        LSQ_BUSY: begin
          if (cache_ready) begin
            state_q       <= LSQ_IDLE;
            cache_valid_q <= 1'b0;
            // A flush arriving with the return still suppresses the result.
            if (!flush) begin
              lsq_ready_q  <= 1'b1;
              lsq_rob_id_q <= inflight_rob_q;
              lsq_value_q  <= inflight_store_q ? 32'd0 : cache_res;
            end
          end else if (flush) begin
            state_q <= LSQ_DRAIN;
          end
        end
        LSQ_DRAIN: begin
          if (cache_ready) begin
            state_q       <= LSQ_IDLE;
            cache_valid_q <= 1'b0;
          end
        end
        default: state_q <= LSQ_IDLE;
      endcase
    end
  end

  assign cache_valid = cache_valid_q;
  assign cache_wr    = cache_wr_q;
  assign cache_size  = cache_size_q;
  assign cache_addr  = cache_addr_q;
  assign cache_value = cache_value_q;
  assign lsq_ready   = lsq_ready_q;
  assign lsq_rob_id  = lsq_rob_id_q;
  assign lsq_value   = lsq_value_q;

`ifdef LSQ_PERF_CNT_EN
  logic [31:0] perf_loads_q, perf_stores_q, perf_stall_q;
  logic        done_ok;

  assign done_ok = pop_en;

  // Saturating counters of completed ops and head stall cycles.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (done_ok && !inflight_store_q && (perf_loads_q != '1))
        perf_loads_q <= perf_loads_q + 32'd1;
      if (done_ok && inflight_store_q && (perf_stores_q != '1))
        perf_stores_q <= perf_stores_q + 32'd1;
      if (rdy_in && (state_q == LSQ_IDLE) && busy_q[head_q] && !issue_ok && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_loads        = perf_loads_q;
  assign perf_stores       = perf_stores_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
